// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state/op encodings and grant-index width helper shared by the arbiter files
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, RD_A, RD_D, WR} state_e;
  typedef enum logic {READ, WRITE} op_e;
  function automatic int gnt_wdth(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after last_gnt
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int GNT_WDTH = gnt_wdth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [GNT_WDTH-1:0] last_gnt,
  output logic [GNT_WDTH-1:0] gnt,
  output logic                any_req
);
  logic [GNT_WDTH:0] cand;
  // Walk from the farthest candidate back to the nearest so the nearest requester wins
  always_comb begin
    gnt  = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last_gnt} + (GNT_WDTH+1)'(k);
      cand = (cand >= (GNT_WDTH+1)'(NUM_REQ)) ? cand - (GNT_WDTH+1)'(NUM_REQ) : cand;
      if (req[cand[GNT_WDTH-1:0]]) gnt = cand[GNT_WDTH-1:0];
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AR/R/AW/W memory port among NUM_REQ requesters, one transaction at a time
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             s_ar_valid,
  output logic [NUM_REQ-1:0]             s_ar_ready,
  input  logic [NUM_REQ*ADDR_WDTH-1:0]   s_ar_address,
  output logic [NUM_REQ-1:0]             s_r_valid,
  input  logic [NUM_REQ-1:0]             s_r_ready,
  output logic [NUM_REQ*RESP_WDTH-1:0]   s_r_resp,
  output logic [NUM_REQ*DATA_WDTH-1:0]   s_r_data,
  input  logic [NUM_REQ-1:0]             s_aw_valid,
  output logic [NUM_REQ-1:0]             s_aw_ready,
  input  logic [NUM_REQ*ADDR_WDTH-1:0]   s_aw_address,
  input  logic [NUM_REQ-1:0]             s_w_valid,
  output logic [NUM_REQ-1:0]             s_w_ready,
  input  logic [NUM_REQ*DATA_WDTH-1:0]   s_w_data,
  output logic                           m_ar_valid,
  input  logic                           m_ar_ready,
  output logic [ADDR_WDTH-1:0]           m_ar_address,
  input  logic                           m_r_valid,
  output logic                           m_r_ready,
  input  logic [RESP_WDTH-1:0]           m_r_resp,
  input  logic [DATA_WDTH-1:0]           m_r_data,
  output logic                           m_aw_valid,
  input  logic                           m_aw_ready,
  output logic [ADDR_WDTH-1:0]           m_aw_address,
  output logic                           m_w_valid,
  input  logic                           m_w_ready,
  output logic [DATA_WDTH-1:0]           m_w_data
);
  localparam int GW = gnt_wdth(NUM_REQ);
  state_e          state_q, state_d;
  op_e             op;
  logic [GW-1:0]   gnt_q, gnt_d, last_gnt_q, last_gnt_d, pick;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            any_req, aw_now, w_now;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .GNT_WDTH(GW)) u_rr (
    .req      (s_ar_valid | s_aw_valid),
    .last_gnt (last_gnt_q),
    .gnt      (pick),
    .any_req  (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_gnt_q <= GW'(NUM_REQ-1);
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_gnt_d   = last_gnt_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    op           = s_ar_valid[pick] ? READ : WRITE;
    aw_now       = 1'b0;
    w_now        = 1'b0;
    s_ar_ready   = '0;
    s_r_valid    = '0;
    s_r_resp     = '0;
    s_r_data     = '0;
    s_aw_ready   = '0;
    s_w_ready    = '0;
    m_ar_valid   = 1'b0;
    m_ar_address = '0;
    m_r_ready    = 1'b0;
    m_aw_valid   = 1'b0;
    m_aw_address = '0;
    m_w_valid    = 1'b0;
    m_w_data     = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          state_d = (op == READ) ? RD_A : WR;
        end
      end
      RD_A: begin
        m_ar_valid        = s_ar_valid[gnt_q];
        m_ar_address      = s_ar_address[gnt_q*ADDR_WDTH +: ADDR_WDTH];
        s_ar_ready[gnt_q] = m_ar_ready;
        state_d           = (m_ar_valid && m_ar_ready) ? RD_D : RD_A;
      end
      RD_D: begin
        s_r_valid[gnt_q]                         = m_r_valid;
        s_r_resp[gnt_q*RESP_WDTH +: RESP_WDTH]   = m_r_resp;
        s_r_data[gnt_q*DATA_WDTH +: DATA_WDTH]   = m_r_data;
        m_r_ready                                = s_r_ready[gnt_q];
        if (m_r_valid && m_r_ready) begin
          last_gnt_d = gnt_q;
          state_d    = IDLE;
        end
      end
      WR: begin
        m_aw_valid        = s_aw_valid[gnt_q] & ~aw_done_q;
        m_aw_address      = s_aw_address[gnt_q*ADDR_WDTH +: ADDR_WDTH];
        m_w_valid         = s_w_valid[gnt_q] & ~w_done_q;
        m_w_data          = s_w_data[gnt_q*DATA_WDTH +: DATA_WDTH];
        s_aw_ready[gnt_q] = m_aw_ready & ~aw_done_q;
        s_w_ready[gnt_q]  = m_w_ready & ~w_done_q;
        aw_now            = aw_done_q | (m_aw_valid & m_aw_ready);
        w_now             = w_done_q | (m_w_valid & m_w_ready);
        // Flags only latch while the other half is still outstanding; both done clears them
        aw_done_d         = aw_now & ~w_now;
        w_done_d          = w_now & ~aw_now;
        if (aw_now && w_now) begin
          last_gnt_d = gnt_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port AR/R/AW/W memory between NUM_REQ requesters, for example several sorter lanes. It allows one transaction in flight at a time and arbitrates round-robin, with reads preferred over writes within the granted requester. Requesters use the same channel protocol on their side. The memory-facing side connects directly to the memory block.

Parameters:
NUM_REQ, 2, number of requesters (legal range 2..8)
ADDR_WDTH, 4, address width
DATA_WDTH, 32, data width
RESP_WDTH, 1, read response width

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
s_ar_valid / s_ar_ready / s_ar_address  in / out / in  NUM_REQ / NUM_REQ / NUM_REQ*ADDR_WDTH  requester AR channels; lane i at bits [i*W +: W]
s_r_valid / s_r_ready / s_r_resp / s_r_data  out / in / out / out  NUM_REQ / NUM_REQ / NUM_REQ*RESP_WDTH / NUM_REQ*DATA_WDTH  requester R channels
s_aw_valid / s_aw_ready / s_aw_address  in / out / in  NUM_REQ / NUM_REQ / NUM_REQ*ADDR_WDTH  requester AW channels
s_w_valid / s_w_ready / s_w_data  in / out / in  NUM_REQ / NUM_REQ / NUM_REQ*DATA_WDTH  requester W channels
m_ar_valid / m_ar_ready / m_ar_address  out / in / out  1 / 1 / ADDR_WDTH  memory AR channel
m_r_valid / m_r_ready / m_r_resp / m_r_data  in / out / in / in  1 / 1 / RESP_WDTH / DATA_WDTH  memory R channel
m_aw_valid / m_aw_ready / m_aw_address  out / in / out  1 / 1 / ADDR_WDTH  memory AW channel
m_w_valid / m_w_ready / m_w_data  out / in / out  1 / 1 / DATA_WDTH  memory W channel

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, gnt=0, last_gnt=NUM_REQ-1, aw_done=w_done=0.
  - All valid/ready outputs are 0; all address/data/resp outputs are 0.
- Handshake: a transfer occurs on a cycle with valid & ready. A requester holds valid and payload stable until its handshake.
- req[i] = s_ar_valid[i] | s_aw_valid[i].
- IDLE:
  - If any req is set, pick the first requesting index after last_gnt, wrapping modulo NUM_REQ.
  - Register gnt and op: READ if s_ar_valid[gnt], else WRITE.
  - Go to RD_A or WR. Arbitration costs exactly one bubble cycle.
  - No outputs are asserted in IDLE.
- RD_A:
  - m_ar_valid = s_ar_valid[gnt]; m_ar_address = lane gnt; s_ar_ready[gnt] = m_ar_ready.
  - On handshake go to RD_D.
- RD_D:
  - s_r_valid[gnt] = m_r_valid; m_r_ready = s_r_ready[gnt]; resp/data are routed to lane gnt only.
  - On handshake: last_gnt = gnt, go to IDLE.
- WR:
  - m_aw_valid = s_aw_valid[gnt] & ~aw_done; m_w_valid = s_w_valid[gnt] & ~w_done.
  - Ready signals are routed back to lane gnt, masked by the corresponding done flag.
  - The AW and W handshakes may complete in either order or in the same cycle; each sets its done flag.
  - When both are done (counting the current cycle): clear the flags, last_gnt = gnt, go to IDLE.
- Outputs outside the active channel:
  - All lanes other than gnt see ready=0, valid=0 and zero data.
  - m_r_ready=0 outside RD_D.
  - The memory-side valid of any channel not active in the current state is 0.
- Minimum latency: read 3 cycles (IDLE, RD_A, RD_D); write 2 cycles (IDLE, WR).
- Fairness:
  - A requester that just completed a transaction has lowest priority in the next arbitration.
  - No requester waits more than NUM_REQ-1 transactions.
- Simultaneous read and write from the same requester: the read is served first. The write is arbitrated again in a later round.
- Reset mid-transaction: the block returns to IDLE immediately and the in-flight transfer is abandoned. The memory shares rst_n and is reset with it.
- Requests that arrive while not in IDLE wait; they are not queued and not dropped.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE, RD_A, RD_D, WR) and op encoding (READ, WRITE);
  - constant GNT_WDTH = clog2(NUM_REQ), minimum 1.
- Sub-module rr_arbiter: combinational round-robin pick. Inputs are req[NUM_REQ-1:0] and last_gnt; outputs are gnt index and any_req.
- mem_arbiter holds the FSM, the done flags and the channel muxing.

Test Plan:
- Reset check: rst_n low with all inputs active -> every output is 0. After release, the first request from lane 0 is granted at the second edge.
- Single read: lane 1 AR addr=5; memory returns data=0xDEADBEEF with ar_ready 1 cycle late -> lane 1 gets s_r_data=0xDEADBEEF, resp routed; lane 0 outputs stay 0.
- Contention: lanes 0 and 1 both issue continuous reads -> grants alternate 0,1,0,1 across 4 transactions. No lane is starved.
- Write ordering: lane 0 writes addr=3 data=0x12; m_w_ready arrives 2 cycles before m_aw_ready, then the same cycle in a second write -> exactly one handshake per channel per write, and the block returns to IDLE after the later handshake.
- Read priority: lane 0 asserts AR and AW simultaneously -> the read completes first; the write follows after lane 1's pending transaction, if lane 1 was requesting.
- Reset mid-read in RD_D with m_r_valid held low -> state returns to IDLE and all ready/valid outputs drop asynchronously. The next request proceeds normally.
